// File: rtl/input_debouncer.sv
// Two-flop synchronizer + 4-state debounce FSM producing a clean, registered level.
// Optional `DEBOUNCE_EDGE_EN adds registered one-clock rise/fall pulses on y transitions.
module input_debouncer #(
  parameter int CNT_W         = 4,
  parameter int STABLE_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  output logic y,
  output logic busy
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > (2**CNT_W) - 1) begin : g_bad_param
    $fatal(1, "input_debouncer: STABLE_CYCLES=%0d outside 1..%0d", STABLE_CYCLES, (2**CNT_W) - 1);
  end

  typedef enum logic [1:0] {LOW, CHK_HIGH, HIGH, CHK_LOW} state_e;

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(STABLE_CYCLES - 1);
  localparam bit               SINGLE = (STABLE_CYCLES == 1);

  state_e           state_q, state_d;
  logic [1:0]       sync_q;
  logic             a_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done;
  logic             y_q, y_d, busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], a};
  end

  assign a_s = sync_q[1];

  // Entry loads cnt=1, so a single-cycle qualify exits on the edge right after entry.
  assign done = SINGLE || (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      LOW: begin
        if (a_s) begin
          state_d = CHK_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      CHK_HIGH: begin
        if (!a_s)     state_d = LOW;
        else if (done) state_d = HIGH;
        else           cnt_d   = cnt_q + 1'b1;
      end
      HIGH: begin
        if (!a_s) begin
          state_d = CHK_LOW;
          cnt_d   = CNT_W'(1);
        end
      end
      CHK_LOW: begin
        if (a_s)       state_d = HIGH;
        else if (done) state_d = LOW;
        else           cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = LOW;
    endcase
  end

  assign y_d    = (state_d == HIGH) || (state_d == CHK_LOW);
  assign busy_d = (state_d == CHK_HIGH) || (state_d == CHK_LOW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOW;
      cnt_q   <= '0;
      y_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
    end
  end

  assign y    = y_q;
  assign busy = busy_q;

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= y_d & ~y_q;
      fall_q <= ~y_d & y_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: default instance (10 cycles) and a 1-cycle instance share one input;
// a window-based model predicts y/busy every cycle, literal checks pin the key edges.
module tb_input_debouncer;

  logic clk, rst_n, a;
  logic y0, busy0, y1, busy1;
`ifdef DEBOUNCE_EDGE_EN
  logic rise0, fall0, rise1, fall1;
`endif

  input_debouncer u_dut0 (
    .clk(clk), .rst_n(rst_n), .a(a), .y(y0), .busy(busy0)
`ifdef DEBOUNCE_EDGE_EN
    , .rise(rise0), .fall(fall0)
`endif
  );

  input_debouncer #(.CNT_W(1), .STABLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .y(y1), .busy(busy1)
`ifdef DEBOUNCE_EDGE_EN
    , .rise(rise1), .fall(fall1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: y flips once the synchronized input has disagreed with y on the last N
  // observing edges (N = STABLE_CYCLES, min 2: entry edge plus exit edge).
  int unsigned nreq [2] = '{10, 2};
  bit  s1_m = 0, as_m = 0;
  bit  hist[$];
  bit  y_m[2]    = '{0, 0};
  bit  busy_m[2] = '{0, 0};
  bit  rise_m[2] = '{0, 0};
  bit  fall_m[2] = '{0, 0};
  int  ec = 0;

  initial begin
    bit flip;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        s1_m = 0; as_m = 0; hist.delete(); ec = 0;
        for (int d = 0; d < 2; d++) begin
          y_m[d] = 0; busy_m[d] = 0; rise_m[d] = 0; fall_m[d] = 0;
        end
      end else begin
        ec++;
        hist.push_back(as_m);
        if (hist.size() > 16) void'(hist.pop_front());
        as_m = s1_m;
        s1_m = a;
        for (int d = 0; d < 2; d++) begin
          flip = (hist.size() >= int'(nreq[d]));
          for (int i = 0; i < int'(nreq[d]) && flip; i++)
            if (hist[hist.size() - 1 - i] == y_m[d]) flip = 0;
          rise_m[d] = flip && !y_m[d];
          fall_m[d] = flip && y_m[d];
          if (flip) y_m[d] = !y_m[d];
          busy_m[d] = (hist[hist.size() - 1] != y_m[d]);
        end
      end
    end
  end

  int rise_n0 = 0, fall_n0 = 0;

  always @(negedge clk) begin
    check("y0", y0, y_m[0]);
    check("busy0", busy0, busy_m[0]);
    check("y1", y1, y_m[1]);
    check("busy1", busy1, busy_m[1]);
`ifdef DEBOUNCE_EDGE_EN
    check("rise0", rise0, rise_m[0]);
    check("fall0", fall0, fall_m[0]);
    check("rise1", rise1, rise_m[1]);
    check("fall1", fall1, fall_m[1]);
    check("rise0&fall0", rise0 & fall0, 1'b0);
    if (rise0 === 1'b1) rise_n0++;
    if (fall0 === 1'b1) fall_n0++;
`endif
  end

  // Hold a at v for n clocks; returns at the negedge after the last sampling edge.
  task automatic cyc(input logic v, input int n);
    repeat (n) begin
      a = v;
      @(negedge clk);
    end
  endtask

  int runs [12] = '{3, 1, 12, 2, 11, 10, 9, 13, 1, 1, 15, 4};

  initial begin
    int r0, f0;
    rst_n = 1'b0;
    a     = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_y0", y0, 1'b0);
    check("rst_busy0", busy0, 1'b0);

    // Release with a held high: busy at edge 3, y at edge 12 (1-cycle instance: edge 4).
    rst_n = 1'b1;
    cyc(1, 2);  check("e2_busy0", busy0, 1'b0);
    cyc(1, 1);  check("e3_busy0", busy0, 1'b1); check("e3_y0", y0, 1'b0);
                check("e3_busy1", busy1, 1'b1); check("e3_y1", y1, 1'b0);
    cyc(1, 1);  check("e4_y1", y1, 1'b1);     check("e4_busy1", busy1, 1'b0);
    cyc(1, 7);  check("e11_y0", y0, 1'b0);    check("e11_busy0", busy0, 1'b1);
    cyc(1, 1);  check("e12_y0", y0, 1'b1);    check("e12_busy0", busy0, 1'b0);
`ifdef DEBOUNCE_EDGE_EN
    check("e12_rise0", rise0, 1'b1);
`endif
    cyc(1, 3);

    // Clean fall sampled at edge k.
    cyc(0, 1);  check("k_busy0", busy0, 1'b0);
    cyc(0, 1);  check("k1_busy0", busy0, 1'b0);
    cyc(0, 1);  check("k2_busy0", busy0, 1'b1);
    cyc(0, 8);  check("k10_y0", y0, 1'b1);    check("k10_busy0", busy0, 1'b1);
    cyc(0, 1);  check("k11_y0", y0, 1'b0);    check("k11_busy0", busy0, 1'b0);
`ifdef DEBOUNCE_EDGE_EN
    check("k11_fall0", fall0, 1'b1);
    check("one_rise0", 1'(rise_n0 == 1), 1'b1);
    check("one_fall0", 1'(fall_n0 == 1), 1'b1);
`endif
    cyc(0, 4);

    // Bounce rejection on the default instance.
    r0 = rise_n0; f0 = fall_n0;
    cyc(1, 5); cyc(0, 2); cyc(1, 4); cyc(0, 14);
    check("bounce_y0", y0, 1'b0);
    check("bounce_busy0", busy0, 1'b0);
`ifdef DEBOUNCE_EDGE_EN
    check("bounce_no_edge0", 1'(rise_n0 == r0 && fall_n0 == f0), 1'b1);
`endif

    // 1-clock glitch is filtered by the 1-cycle instance; a 2-clock pulse passes.
    cyc(1, 1); cyc(0, 6);
    check("glitch_y1", y1, 1'b0);
    cyc(1, 2); cyc(0, 2);
    check("pulse2_y1", y1, 1'b1);
    cyc(0, 6);

    // Async reset mid-qualification at edge 8 (CHK_HIGH, cnt=6).
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 8);
    check("mid_busy0_pre", busy0, 1'b1);
    check("mid_y1_pre", y1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_y0", y0, 1'b0);
    check("mid_busy0", busy0, 1'b0);
    check("mid_y1", y1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 11); check("rel11_y0", y0, 1'b0);
    cyc(1, 1);  check("rel12_y0", y0, 1'b1);

    // Mixed run lengths around the qualification threshold.
    for (int i = 0; i < 12; i++) cyc(logic'(i % 2), runs[i]);
    cyc(0, 15);
    check("end_y0", y0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
